// File: rtl/riscv_main_control.sv
// Multi-cycle RISC-V main control FSM: decodes opcode, sequences datapath.
// Ports: clk, reset, opcode, zero, memReady in; mux selects, enables, state out.
module riscv_main_control #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         opcode,
  input  logic               zero,
  input  logic               memReady,
  output logic [1:0]         aluOp,
  output logic [1:0]         aluSrcA,
  output logic [1:0]         aluSrcB,
  output logic [1:0]         resultSrc,
  output logic               adrSrc,
  output logic               memRead,
  output logic               memWrite,
  output logic               irWrite,
  output logic               regWrite,
  output logic               pcEn,
  output logic               retire,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [STATE_W-1:0] {
    FETCH    = STATE_W'(0),
    DECODE   = STATE_W'(1),
    MEMADR   = STATE_W'(2),
    MEMREAD  = STATE_W'(3),
    MEMWB    = STATE_W'(4),
    MEMWRITE = STATE_W'(5),
    EXECR    = STATE_W'(6),
    EXECI    = STATE_W'(7),
    ALUWB    = STATE_W'(8),
    BEQ      = STATE_W'(9),
    JAL      = STATE_W'(10),
    ERROR    = STATE_W'(11)
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   illegal_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == ERROR)
        illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    if (memReady) state_d = DECODE;
      DECODE: begin
        unique case (1'b1)
          (opcode == OP_LD),
          (opcode == OP_ST):  state_d = MEMADR;
          (opcode == OP_R):   state_d = EXECR;
          (opcode == OP_I):   state_d = EXECI;
          (opcode == OP_BR):  state_d = BEQ;
          (opcode == OP_JAL): state_d = JAL;
          default:            state_d = ERROR;
        endcase
      end
      MEMADR:   state_d = (opcode == OP_LD) ? MEMREAD : MEMWRITE;
      MEMREAD:  if (memReady) state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWRITE: if (memReady) state_d = FETCH;
      EXECR:    state_d = ALUWB;
      EXECI:    state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BEQ:      state_d = FETCH;
      JAL:      state_d = ALUWB;
      ERROR:    state_d = ERROR;
      default:  state_d = ERROR;
    endcase
  end

  // Everything reads 0 while reset is held, so no stray write or PC load.
  always_comb begin
    aluOp     = 2'b00;
    aluSrcA   = 2'b00;
    aluSrcB   = 2'b00;
    resultSrc = 2'b00;
    adrSrc    = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    irWrite   = 1'b0;
    regWrite  = 1'b0;
    pcEn      = 1'b0;
    retire    = 1'b0;
    if (!reset) begin
      case (state_q)
        FETCH: begin
          memRead   = 1'b1;
          aluSrcB   = 2'b10;
          resultSrc = 2'b10;
          irWrite   = memReady;
          pcEn      = memReady;
        end
        DECODE: begin
          aluSrcA = 2'b01;
          aluSrcB = 2'b01;
        end
        MEMADR: begin
          aluSrcA = 2'b10;
          aluSrcB = 2'b01;
        end
        MEMREAD: begin
          memRead = 1'b1;
          adrSrc  = 1'b1;
        end
        MEMWB: begin
          resultSrc = 2'b01;
          regWrite  = 1'b1;
          retire    = 1'b1;
        end
        MEMWRITE: begin
          memWrite = 1'b1;
          adrSrc   = 1'b1;
          retire   = memReady;
        end
        EXECR: begin
          aluSrcA = 2'b10;
          aluOp   = 2'b10;
        end
        EXECI: begin
          aluSrcA = 2'b10;
          aluSrcB = 2'b01;
          aluOp   = 2'b10;
        end
        ALUWB: begin
          regWrite = 1'b1;
          retire   = 1'b1;
        end
        BEQ: begin
          aluSrcA = 2'b10;
          aluOp   = 2'b01;
          pcEn    = zero;
          retire  = 1'b1;
        end
        JAL: begin
          aluSrcA = 2'b01;
          aluSrcB = 2'b10;
          pcEn    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign illegal = illegal_q;
  assign state   = state_q;

endmodule

// File: tb/tb_riscv_main_control.sv
// Bench for riscv_main_control: route-based reference model checked every
// cycle, plus directed literal checks on the key scenarios.
module tb_riscv_main_control;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = RT;
  logic       zero = 1'b0;
  logic       memReady = 1'b1;
  logic [1:0] aluOp, aluSrcA, aluSrcB, resultSrc;
  logic       adrSrc, memRead, memWrite, irWrite;
  logic       regWrite, pcEn, retire, illegal;
  logic [3:0] state;

  riscv_main_control #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .zero(zero), .memReady(memReady),
    .aluOp(aluOp), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
    .resultSrc(resultSrc), .adrSrc(adrSrc),
    .memRead(memRead), .memWrite(memWrite),
    .irWrite(irWrite), .regWrite(regWrite),
    .pcEn(pcEn), .retire(retire),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: after DECODE, an instruction walks a fixed route of steps;
  // FETCH, MEMREAD and MEMWRITE wait on memReady.
  int  ms = 0;
  bit  mill = 1'b0;
  bit  armed = 1'b0;
  int  route[$];

  always @(posedge clk) begin
    if (reset) begin
      ms = 0;
      mill = 1'b0;
      armed = 1'b1;
      route.delete();
    end else if (armed) begin
      if (ms == 0) begin
        if (memReady) ms = 1;
      end else if (ms == 1) begin
        route.delete();
        if (opcode == LW || opcode == SW) route = '{2};
        else if (opcode == RT) route = '{6, 8};
        else if (opcode == IT) route = '{7, 8};
        else if (opcode == BR) route = '{9};
        else if (opcode == JL) route = '{10, 8};
        else route = '{11};
        ms = route.pop_front();
      end else if (ms == 2) begin
        ms = (opcode == LW) ? 3 : 5;
      end else if (ms == 3) begin
        if (memReady) ms = 4;
      end else if (ms == 5) begin
        if (memReady) ms = 0;
      end else if (ms != 11) begin
        ms = (route.size() > 0) ? route.pop_front() : 0;
      end
      if (ms == 11) mill = 1'b1;
    end
  end

  // Packed as {aluOp,aluSrcA,aluSrcB,resultSrc,adrSrc,
  //            memRead,memWrite,irWrite,regWrite,pcEn,retire}
  function automatic logic [14:0] expv(int s, bit r, bit z, bit mr);
    logic [1:0] op, sa, sb, rs;
    logic       ad, rd, wr, ir, rw, pc, rt;
    {op, sa, sb, rs} = '0;
    {ad, rd, wr, ir, rw, pc, rt} = '0;
    case (s)
      0:  begin sb = 2; rs = 2; rd = 1; ir = mr; pc = mr; end
      1:  begin sa = 1; sb = 1; end
      2:  begin sa = 2; sb = 1; end
      3:  begin rd = 1; ad = 1; end
      4:  begin rs = 1; rw = 1; rt = 1; end
      5:  begin wr = 1; ad = 1; rt = mr; end
      6:  begin sa = 2; op = 2; end
      7:  begin sa = 2; sb = 1; op = 2; end
      8:  begin rw = 1; rt = 1; end
      9:  begin sa = 2; op = 1; pc = z; rt = 1; end
      10: begin sa = 1; sb = 2; pc = 1; end
      default: ;
    endcase
    if (r) return '0;
    return {op, sa, sb, rs, ad, rd, wr, ir, rw, pc, rt};
  endfunction

  always @(negedge clk) begin
    if (armed) begin
      chk("outs",
          int'({aluOp, aluSrcA, aluSrcB, resultSrc, adrSrc, memRead,
                memWrite, irWrite, regWrite, pcEn, retire}),
          int'(expv(ms, reset, zero, memReady)));
      chk("state", int'(state), ms);
      chk("illegal", int'(illegal), int'(mill));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_state", state, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_memRead", memRead, 0);
    reset = 1'b0;
    #1 chk("fetch_memRead", memRead, 1);
    tick(); chk("r_s1", state, 1);
    tick(); chk("r_s6", state, 6);
    chk("r_aluOp", aluOp, 2);
    chk("r_regw_early", regWrite, 0);
    tick(); chk("r_s8", state, 8);
    chk("r_regWrite", regWrite, 1);
    chk("r_retire", retire, 1);
    tick(); chk("r_s0", state, 0);

    opcode = LW;
    tick(); chk("lw_s1", state, 1);
    tick(); chk("lw_s2", state, 2);
    tick(); chk("lw_s3", state, 3);
    memReady = 1'b0;
    #1 chk("lw_memRead", memRead, 1);
    chk("lw_adrSrc", adrSrc, 1);
    tick(); chk("lw_s3b", state, 3);
    tick(); chk("lw_s3c", state, 3);
    memReady = 1'b1;
    tick(); chk("lw_s4", state, 4);
    chk("lw_resultSrc", resultSrc, 1);
    chk("lw_regWrite", regWrite, 1);
    tick(); chk("lw_s0", state, 0);

    opcode = IT;
    repeat (4) tick();
    chk("i_done", state, 0);
    opcode = SW;
    repeat (4) tick();
    chk("sw_done", state, 0);

    opcode = JL;
    tick(); tick(); chk("jal_s10", state, 10);
    chk("jal_pcEn", pcEn, 1);
    tick(); chk("jal_s8", state, 8);
    tick(); chk("jal_s0", state, 0);

    opcode = BR;
    zero = 1'b1;
    tick(); tick(); chk("beq_s9", state, 9);
    chk("beq_taken_pcEn", pcEn, 1);
    chk("beq_aluOp", aluOp, 1);
    tick(); chk("beq_s0", state, 0);
    zero = 1'b0;
    tick(); tick(); chk("beqn_s9", state, 9);
    chk("beq_nt_pcEn", pcEn, 0);
    tick(); chk("beqn_s0", state, 0);

    memReady = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_irWrite", irWrite, 0);
      chk("stall_pcEn", pcEn, 0);
      chk("stall_memRead", memRead, 1);
      tick();
    end
    chk("stall_s0", state, 0);
    memReady = 1'b1;
    #1 chk("go_irWrite", irWrite, 1);
    chk("go_pcEn", pcEn, 1);
    opcode = BAD;
    tick(); chk("ill_s1", state, 1);
    tick(); chk("ill_s11", state, 11);
    for (int i = 0; i < 10; i++) begin
      chk("err_illegal", illegal, 1);
      chk("err_memRead", memRead, 0);
      tick();
    end
    chk("err_stuck", state, 11);
    reset = 1'b1;
    tick(); chk("err_rst_state", state, 0);
    chk("err_rst_illegal", illegal, 0);
    reset = 1'b0;

    opcode = SW;
    tick(); tick(); tick(); chk("swr_s5", state, 5);
    memReady = 1'b0;
    #1 chk("swr_memWrite", memWrite, 1);
    tick(); chk("swr_hold", state, 5);
    reset = 1'b1;
    #1 chk("swr_rst_memWrite", memWrite, 0);
    tick(); chk("swr_rst_state", state, 0);
    reset = 1'b0;
    memReady = 1'b1;
    opcode = RT;
    repeat (4) tick();
    chk("after_r", state, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_main_control.md
Name: riscv_main_control

Overview:
- Multi-cycle RISC-V main control FSM.
- Decodes the 7-bit opcode of the fetched instruction and sequences the datapath one step per clock.
- Produces the 2-bit aluOp consumed by alu_control, plus all register, memory and PC enables.
- Sits between instruction register and datapath; memory accesses are stretched by a ready handshake.

Parameters:
- STATE_W, 4, width of state encoding / debug port.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- opcode  input  7  instruction[6:0] from instruction register
- zero  input  1  ALU zero flag
- memReady  input  1  memory has completed current read/write this cycle
- aluOp  output  2  00 add, 01 sub (branch compare), 10 decode funct3/funct7
- aluSrcA  output  2  00 PC, 01 oldPC, 10 rs1
- aluSrcB  output  2  00 rs2, 01 immediate, 10 constant 4
- resultSrc  output  2  00 ALUOut, 01 memory data, 10 ALU result direct
- adrSrc  output  1  0 PC, 1 ALUOut
- memRead  output  1  memory read request
- memWrite  output  1  memory write request
- irWrite  output  1  load instruction register
- regWrite  output  1  register file write enable
- pcEn  output  1  PC load enable (includes branch-taken term)
- retire  output  1  one-cycle pulse, instruction completed
- illegal  output  1  sticky unknown-opcode flag
- state  output  STATE_W  current state (debug)

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset: on a clk edge with reset=1, state<=FETCH and illegal<=0. While reset=1, all enables (memRead, memWrite, irWrite, regWrite, pcEn, retire) are forced 0. Mux selects and aluOp read 00.
- Output timing: Moore outputs decoded from the registered state. Exceptions: pcEn also depends on zero and memReady. Any field not listed for a state is 0.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10, ERROR=11.
- FETCH:
  - Outputs: memRead=1, adrSrc=0, aluSrcA=00, aluSrcB=10, aluOp=00, resultSrc=10.
  - irWrite=memReady, pcEn=memReady.
  - Stays in FETCH while memReady=0; goes to DECODE when memReady=1.
- DECODE: aluSrcA=01, aluSrcB=01, aluOp=00 (branch target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - any other -> ERROR
- MEMADR: aluSrcA=10, aluSrcB=01, aluOp=00. Next is MEMREAD if opcode=0000011, else MEMWRITE.
- MEMREAD: memRead=1, adrSrc=1. Holds until memReady=1, then MEMWB.
- MEMWB: resultSrc=01, regWrite=1, retire=1. Next is FETCH.
- MEMWRITE: memWrite=1, adrSrc=1. Holds until memReady=1. On the memReady=1 cycle retire=1, next is FETCH.
- EXECR: aluSrcA=10, aluSrcB=00, aluOp=10. Next is ALUWB.
- EXECI: aluSrcA=10, aluSrcB=01, aluOp=10. Next is ALUWB.
- ALUWB: resultSrc=00, regWrite=1, retire=1. Next is FETCH.
- BEQ: aluSrcA=10, aluSrcB=00, aluOp=01, resultSrc=00. pcEn=zero, retire=1. Next is FETCH.
- JAL: aluSrcA=01, aluSrcB=10, aluOp=00, resultSrc=00, pcEn=1. Next is ALUWB (writes oldPC+4 to rd; retire comes in ALUWB).
- ERROR: all enables 0, illegal=1. Stays in ERROR until reset; no further memory traffic.
- Latency with memReady tied 1: R/I-type 4 cycles, lw 5, sw 4, beq 3, jal 4.
- Simultaneous events: reset wins over memReady and opcode. Opcode is sampled only in DECODE and MEMADR; changes elsewhere are ignored.
- Reset mid-operation: reset asserted in any state, including a MEMWRITE stall, returns to FETCH next edge with no write issued in the reset cycle.
- Encoding: unused encodings 12-15 go to ERROR.

Test Plan:
- Reset then R-type: reset=1 for 2 cycles, memReady=1, opcode=0110011.
  - Required: state sequence 0,1,6,8,0.
  - aluOp=10 in EXECR; regWrite=1 and retire=1 only in ALUWB.
- lw with 2-cycle memory stall: opcode=0000011, memReady=0 for the first 2 cycles of MEMREAD.
  - Required: sequence 0,1,2,3,3,3,4,0.
  - memRead=1 and adrSrc=1 throughout MEMREAD; resultSrc=01 and regWrite=1 in MEMWB.
- beq taken vs not taken: opcode=1100011.
  - zero=1 -> pcEn=1 in BEQ, aluOp=01.
  - zero=0 -> pcEn=0.
  - Both cases return to FETCH after 3 cycles.
- Fetch stall: memReady=0 for 3 cycles in FETCH.
  - Required: irWrite=0 and pcEn=0 for those cycles, memRead=1.
  - On the 4th cycle (memReady=1): irWrite=1, pcEn=1, then DECODE.
- Illegal opcode 1111111:
  - Required: DECODE -> ERROR; illegal=1 and all enables 0 for 10 cycles.
  - reset=1 -> FETCH with illegal=0.
- Reset during sw stall: opcode=0100011, memReady=0 in MEMWRITE, assert reset.
  - Required: memWrite=0 in the reset cycle; state=FETCH next edge.
